// File: rtl/ccip_if_pkg.sv
// rtl/ccip_if_pkg.sv - CCI-P c0 channel types used by the read arbiter
package ccip_if_pkg;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        logic [15:0]  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

endpackage

// File: rtl/platform_utils_ccip_arb_pkg.sv
// rtl/platform_utils_ccip_arb_pkg.sv - shared types for the CCI-P request arbiters
package platform_utils_ccip_arb_pkg;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        RESERVE0 = 2'd1,
        RESERVE1 = 2'd2
    } t_c0_rd_arb_state;

    typedef logic [2:0] t_cl_lines;

    // cl_len encodes 1, 2 or 4 lines as 0, 1, 3
    function automatic t_cl_lines cl_lines(input logic [1:0] cl_len);
        return {1'b0, cl_len} + 3'd1;
    endfunction

endpackage

// File: rtl/platform_utils_rr_arb2.sv
// rtl/platform_utils_rr_arb2.sv - two-input round-robin picker, one-hot grant
module platform_utils_rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On contention the requester that did not win last time goes first
    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/platform_utils_ccip_c0_rd_arb.sv
// rtl/platform_utils_ccip_c0_rd_arb.sv - credit-limited two-port c0 read arbiter with starvation reserve
module platform_utils_ccip_c0_rd_arb
    import ccip_if_pkg::*;
    import platform_utils_ccip_arb_pkg::*;
#(
    parameter int MAX_ACTIVE       = 512,
    parameter int C0RX_DEPTH_RADIX = 10,
    parameter int STARVE_LIMIT     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req0_valid,
    input  t_ccip_c0_ReqMemHdr          req0_hdr,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  t_ccip_c0_ReqMemHdr          req1_hdr,
    output logic                        req1_ready,
    input  logic                        c0TxAlmFull,
    output t_if_ccip_c0_Tx              c0Tx,
    input  t_if_ccip_c0_Rx              c0Rx,
    output logic [C0RX_DEPTH_RADIX-1:0] active_cnt,
    output logic                        cnt_err
);

    localparam int CW = C0RX_DEPTH_RADIX + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] MAX_W   = CW'(MAX_ACTIVE);
    localparam logic [WW-1:0] LIMIT_W = WW'(STARVE_LIMIT);

    t_c0_rd_arb_state            state;
    logic [C0RX_DEPTH_RADIX-1:0] cnt;
    logic                        last_grant;
    logic [WW-1:0]               wait0, wait1, wait0_next, wait1_next;
    t_cl_lines                   lines0, lines1, grant_lines;
    logic                        credit0, credit1, rd_rsp;
    logic [1:0]                  eligible, masked, grant;
    logic [CW-1:0]               cnt_plus;
    logic                        unused_rx;

    assign active_cnt = cnt;
    assign unused_rx  = ^c0Rx;

    // Credit check uses the registered count only; same-cycle responses are not credited
    always_comb begin
        lines0   = cl_lines(req0_hdr.cl_len);
        lines1   = cl_lines(req1_hdr.cl_len);
        credit0  = ({1'b0, cnt} + CW'(lines0)) <= MAX_W;
        credit1  = ({1'b0, cnt} + CW'(lines1)) <= MAX_W;
        eligible = {req1_valid && !c0TxAlmFull && credit1,
                    req0_valid && !c0TxAlmFull && credit0};
        case (state)
            ARB:      masked = eligible;
            RESERVE0: masked = {1'b0, eligible[0]};
            RESERVE1: masked = {eligible[1], 1'b0};
            default:  masked = 2'b00;
        endcase
    end

    platform_utils_rr_arb2 u_rr (
        .eligible   (masked),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = grant[0] && !reset;
    assign req1_ready = grant[1] && !reset;

    always_comb begin
        grant_lines = grant[1] ? lines1 : (grant[0] ? lines0 : 3'd0);
        cnt_plus    = {1'b0, cnt} + CW'(grant_lines);
        rd_rsp      = c0Rx.rspValid && (c0Rx.hdr.resp_type == eRSP_RDLINE);

        wait0_next = wait0;
        if (grant[0] || !req0_valid) begin
            wait0_next = '0;
        end else if (!c0TxAlmFull && !credit0 && wait0 != LIMIT_W) begin
            wait0_next = wait0 + 1'b1;
        end

        wait1_next = wait1;
        if (grant[1] || !req1_valid) begin
            wait1_next = '0;
        end else if (!c0TxAlmFull && !credit1 && wait1 != LIMIT_W) begin
            wait1_next = wait1 + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            cnt        <= '0;
            cnt_err    <= 1'b0;
            last_grant <= 1'b1;
            wait0      <= '0;
            wait1      <= '0;
            c0Tx       <= '0;
        end else begin
            wait0      <= wait0_next;
            wait1      <= wait1_next;
            c0Tx.valid <= |grant;
            if (|grant) begin
                c0Tx.hdr   <= grant[1] ? req1_hdr : req0_hdr;
                last_grant <= grant[1];
            end

            // An orphan response cannot underflow; it is flagged instead
            if (rd_rsp) begin
                if (cnt_plus == '0) begin
                    cnt_err <= 1'b1;
                    cnt     <= '0;
                end else begin
                    cnt <= C0RX_DEPTH_RADIX'(cnt_plus - 1'b1);
                end
            end else begin
                cnt <= C0RX_DEPTH_RADIX'(cnt_plus);
            end

            case (state)
                ARB: begin
                    if (wait0_next == LIMIT_W) begin
                        state <= RESERVE0;
                    end else if (wait1_next == LIMIT_W) begin
                        state <= RESERVE1;
                    end
                end
                RESERVE0: if (grant[0] || !req0_valid) state <= ARB;
                RESERVE1: if (grant[1] || !req1_valid) state <= ARB;
                default:  state <= ARB;
            endcase
        end
    end

endmodule
